// File: rtl/traffic_light_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl_pkg
//  Description : State encodings, lamp codes and helpers for the intersection
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_light_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED_A = 3'd0,
        ST_MAIN_G    = 3'd1,
        ST_MAIN_Y    = 3'd2,
        ST_ALL_RED_B = 3'd3,
        ST_SIDE_G    = 3'd4,
        ST_SIDE_Y    = 3'd5,
        ST_FLASH     = 3'd6
    } state_t;

    // Lamp vectors are {R,Y,G}
    localparam logic [2:0] c_lamp_r = 3'b100;
    localparam logic [2:0] c_lamp_y = 3'b010;
    localparam logic [2:0] c_lamp_g = 3'b001;

    function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
        return (v >= lim) ? lim : v + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_ctrl_req_latch.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl_req_latch
//  Description : Side-road demand latch; clear wins over a same-cycle set.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl_req_latch (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic q
);

    logic r_req_q;
    logic w_req_d;

    always_comb begin
        w_req_d = r_req_q;
        if (clr) begin
            w_req_d = 1'b0;
        end else if (set) begin
            w_req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_q <= 1'b0;
        end else begin
            r_req_q <= w_req_d;
        end
    end

    assign q = r_req_q;

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl
//  Description : Main/side road intersection FSM driving an external phase
//                counter, with demand-actuated side green and night flashing.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
    import traffic_light_ctrl_pkg::*;
#(
    parameter int MAIN_GREEN_PERIODS = 2,
    parameter int SIDE_GREEN_PERIODS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       over_flag,
    input  logic       side_req,
    input  logic       night,
    output logic       cnt_clr,
    output logic       sel_compare,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       side_walk
);

    localparam logic [2:0] c_main_lim = 3'(MAIN_GREEN_PERIODS);
    localparam logic [2:0] c_side_lim = 3'(SIDE_GREEN_PERIODS);

    state_t     r_state_q;
    state_t     w_state_d;
    logic [2:0] r_period_q;
    logic [2:0] w_period_d;
    logic       r_flash_ph_q;
    logic       w_flash_ph_d;
    logic       r_cnt_clr_q;
    logic       w_cnt_clr_d;
    logic       w_req_clr;
    logic       w_req_lat;

    traffic_light_ctrl_req_latch u_req_latch (
        .clk   (clk),
        .reset (reset),
        .set   (side_req),
        .clr   (w_req_clr),
        .q     (w_req_lat)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_period_d   = r_period_q;
        w_flash_ph_d = r_flash_ph_q;
        w_req_clr    = 1'b0;
        w_cnt_clr_d  = over_flag;
        sel_compare  = 1'b0;
        side_walk    = 1'b0;
        main_lamp    = c_lamp_r;
        side_lamp    = c_lamp_r;

        case (r_state_q)
            ST_ALL_RED_A: begin
                if (over_flag) w_state_d = night ? ST_FLASH : ST_MAIN_G;
            end
            ST_MAIN_G: begin
                sel_compare = 1'b1;
                main_lamp   = c_lamp_g;
                if (over_flag) begin
                    w_period_d = sat_inc(r_period_q, c_main_lim);
                    if ((w_period_d == c_main_lim) && (w_req_lat || night))
                        w_state_d = ST_MAIN_Y;
                end
            end
            ST_MAIN_Y: begin
                main_lamp = c_lamp_y;
                if (over_flag) w_state_d = ST_ALL_RED_B;
            end
            ST_ALL_RED_B: begin
                if (over_flag) begin
                    if (night) begin
                        w_state_d = ST_FLASH;
                    end else begin
                        // Demand pending on this edge is served by the green we enter
                        w_state_d = ST_SIDE_G;
                        w_req_clr = 1'b1;
                    end
                end
            end
            ST_SIDE_G: begin
                sel_compare = 1'b1;
                side_lamp   = c_lamp_g;
                side_walk   = 1'b1;
                if (over_flag) begin
                    w_period_d = sat_inc(r_period_q, c_side_lim);
                    if (w_period_d == c_side_lim) w_state_d = ST_SIDE_Y;
                end
            end
            ST_SIDE_Y: begin
                side_lamp = c_lamp_y;
                if (over_flag) w_state_d = ST_ALL_RED_A;
            end
            ST_FLASH: begin
                main_lamp = {1'b0, r_flash_ph_q, 1'b0};
                side_lamp = {r_flash_ph_q, 2'b00};
                if (over_flag) begin
                    w_flash_ph_d = ~r_flash_ph_q;
                    if (!night) w_state_d = ST_ALL_RED_A;
                end
            end
            default: begin
                w_state_d = ST_ALL_RED_A;
            end
        endcase

        if (w_state_d != r_state_q) w_period_d = 3'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q    <= ST_ALL_RED_A;
            r_period_q   <= 3'd0;
            r_flash_ph_q <= 1'b0;
            r_cnt_clr_q  <= 1'b1;
        end else begin
            r_state_q    <= w_state_d;
            r_period_q   <= w_period_d;
            r_flash_ph_q <= w_flash_ph_d;
            r_cnt_clr_q  <= w_cnt_clr_d;
        end
    end

    assign cnt_clr = r_cnt_clr_q;

endmodule
`default_nettype wire
